// File: rtl/dest_dispatch_pkg.sv
// Shared definitions for the destination dispatcher: slot layout, FSM encoding
// and the warehouse coordinate table also used by the order-mapping stage.
package dest_dispatch_pkg;

    localparam int SLOT_W = 16;
    localparam int X_LSB  = 0;
    localparam int Y_LSB  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOME  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Slot encoding is {y, x}
    localparam logic [SLOT_W-1:0] COORD_06_30 = 16'h3006;
    localparam logic [SLOT_W-1:0] COORD_22_30 = 16'h3022;
    localparam logic [SLOT_W-1:0] COORD_52_30 = 16'h3052;
    localparam logic [SLOT_W-1:0] COORD_56_90 = 16'h9056;
    localparam logic [SLOT_W-1:0] COORD_82_90 = 16'h9082;
    localparam logic [SLOT_W-1:0] COORD_A6_90 = 16'h90a6;
    localparam logic [SLOT_W-1:0] COORD_HOME  = 16'h0000;

    function automatic logic [7:0] slot_x(input logic [SLOT_W-1:0] slot);
        return slot[X_LSB +: 8];
    endfunction

    function automatic logic [7:0] slot_y(input logic [SLOT_W-1:0] slot);
        return slot[Y_LSB +: 8];
    endfunction

endpackage

// File: rtl/dest_dispatch_slot_counter.sv
// Counts consecutive non-empty slots from slot 0; a slot is empty when both
// coordinate bytes are zero.
module slot_counter
    import dest_dispatch_pkg::*;
#(
    parameter int N_SLOTS = 6
) (
    input  logic [SLOT_W*N_SLOTS-1:0] destn,
    output logic [2:0]                count
);

    logic stop;

    always_comb begin
        count = '0;
        stop  = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (!stop) begin
                if (destn[k*SLOT_W +: SLOT_W] != '0) begin
                    count = count + 3'd1;
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dest_dispatch.sv
// Snapshots a packed destination list on load and issues each entry over a
// valid/ack handshake, optionally followed by a home waypoint, then pulses done.
module dest_dispatch
    import dest_dispatch_pkg::*;
#(
    parameter int         N_SLOTS     = 6,
    parameter bit         RETURN_HOME = 1'b1,
    parameter logic [7:0] HOME_X      = 8'h00,
    parameter logic [7:0] HOME_Y      = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SLOT_W*N_SLOTS-1:0] destn_in,
    input  logic                      load,
    input  logic                      abort,
    output logic                      wp_valid,
    output logic [7:0]                wp_x,
    output logic [7:0]                wp_y,
    output logic                      wp_home,
    input  logic                      wp_ack,
    output logic [2:0]                wp_index,
    output logic                      busy,
    output logic                      done
);

    // Handshake: a waypoint is transferred on any cycle where wp_valid and
    // wp_ack are both high; wp_ack with wp_valid low has no effect.

    state_t                    state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic [2:0]                count_q, count_d;
    logic [2:0]                count_live;
    logic [SLOT_W*N_SLOTS-1:0] snap_q, snap_d;
    logic [SLOT_W*N_SLOTS-1:0] src;
    logic [SLOT_W-1:0]         slot_d;
    logic                      last_slot;

    logic                      wp_valid_d, wp_home_d, busy_d, done_d;
    logic [7:0]                wp_x_d, wp_y_d;
    logic [2:0]                wp_index_d;

    slot_counter #(.N_SLOTS(N_SLOTS)) u_slot_counter (
        .destn (destn_in),
        .count (count_live)
    );

    assign last_slot = !(({1'b0, idx_q} + 4'd1) < {1'b0, count_q});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    snap_d  = destn_in;
                    count_d = count_live;
                    idx_d   = '0;
                    state_d = (count_live != '0) ? ST_ISSUE : ST_FIN;
                end
            end
            ST_ISSUE: begin
                // abort takes priority and swallows a coincident ack
                if (abort) begin
                    state_d = RETURN_HOME ? ST_HOME : ST_FIN;
                end else if (wp_ack) begin
                    if (!last_slot) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        state_d = RETURN_HOME ? ST_HOME : ST_FIN;
                    end
                end
            end
            ST_HOME: begin
                if (wp_ack) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the next state
    always_comb begin
        src    = (state_q == ST_IDLE) ? destn_in : snap_q;
        slot_d = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (idx_d == 3'(k)) begin
                slot_d = src[k*SLOT_W +: SLOT_W];
            end
        end

        wp_valid_d = (state_d == ST_ISSUE) || (state_d == ST_HOME);
        busy_d     = wp_valid_d;
        done_d     = (state_d == ST_FIN);
        wp_home_d  = (state_d == ST_HOME);
        wp_index_d = wp_valid_d ? idx_d : 3'd0;
        wp_x_d     = '0;
        wp_y_d     = '0;
        if (state_d == ST_ISSUE) begin
            wp_x_d = slot_x(slot_d);
            wp_y_d = slot_y(slot_d);
        end else if (state_d == ST_HOME) begin
            wp_x_d = HOME_X;
            wp_y_d = HOME_Y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            snap_q   <= '0;
            wp_valid <= 1'b0;
            wp_x     <= '0;
            wp_y     <= '0;
            wp_home  <= 1'b0;
            wp_index <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            snap_q   <= snap_d;
            wp_valid <= wp_valid_d;
            wp_x     <= wp_x_d;
            wp_y     <= wp_y_d;
            wp_home  <= wp_home_d;
            wp_index <= wp_index_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_dest_dispatch.sv
// Directed bench for dest_dispatch: a per-cycle vector table on the
// return-home build plus hand sequences for the full list and mid-run reset.
module tb_dest_dispatch;

    localparam int LW = 96;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] destn_in;
    logic          load, abort, wp_ack;

    logic       h_valid, h_home, h_busy, h_done;
    logic [7:0] h_x, h_y;
    logic [2:0] h_idx;
    logic       n_valid, n_home, n_busy, n_done;
    logic [7:0] n_x, n_y;
    logic [2:0] n_idx;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dest_dispatch #(.N_SLOTS(6), .RETURN_HOME(1'b1), .HOME_X(8'h00), .HOME_Y(8'h00)) dut_h (
        .clk(clk), .rst_n(rst_n), .destn_in(destn_in), .load(load), .abort(abort),
        .wp_valid(h_valid), .wp_x(h_x), .wp_y(h_y), .wp_home(h_home), .wp_ack(wp_ack),
        .wp_index(h_idx), .busy(h_busy), .done(h_done)
    );

    dest_dispatch #(.N_SLOTS(6), .RETURN_HOME(1'b0), .HOME_X(8'h00), .HOME_Y(8'h00)) dut_n (
        .clk(clk), .rst_n(rst_n), .destn_in(destn_in), .load(load), .abort(abort),
        .wp_valid(n_valid), .wp_x(n_x), .wp_y(n_y), .wp_home(n_home), .wp_ack(wp_ack),
        .wp_index(n_idx), .busy(n_busy), .done(n_done)
    );

    typedef struct {
        logic [LW-1:0] destn;
        logic          load, abort, ack;
        logic [22:0]   exp;  // {valid, x, y, home, index, busy, done}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [22:0] pk(input logic v, input logic [7:0] x, input logic [7:0] y,
                                       input logic h, input logic [2:0] i, input logic b,
                                       input logic d);
        return {v, x, y, h, i, b, d};
    endfunction

    function automatic logic [22:0] got_h();
        return {h_valid, h_x, h_y, h_home, h_idx, h_busy, h_done};
    endfunction

    function automatic logic [22:0] got_n();
        return {n_valid, n_x, n_y, n_home, n_idx, n_busy, n_done};
    endfunction

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic [LW-1:0] d, input logic l, input logic a, input logic k,
                       input logic [22:0] e);
        vec_t v;
        v.destn = d; v.load = l; v.abort = a; v.ack = k; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [LW-1:0] d, input logic l, input logic a, input logic k);
        @(negedge clk);
        destn_in = d; load = l; abort = a; wp_ack = k;
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0] l2, lgap, l3, lalt, lfull;
    logic [7:0]    fx[6];
    logic [7:0]    fy[6];
    logic [22:0]   zero, e0, e1, ehome1, edone;

    initial begin
        l2    = {64'h0, 16'h3022, 16'h3006};
        lgap  = {48'h0, 16'h9056, 16'h0000, 16'h3052};
        l3    = {48'h0, 16'h3052, 16'h3022, 16'h3006};
        lalt  = {64'h0, 16'h1111, 16'h2222};
        lfull = {16'h90a6, 16'h9082, 16'h9056, 16'h3052, 16'h3022, 16'h3006};
        fx = '{8'h06, 8'h22, 8'h52, 8'h56, 8'h82, 8'ha6};
        fy = '{8'h30, 8'h30, 8'h30, 8'h90, 8'h90, 8'h90};

        zero   = pk(0, 8'h00, 8'h00, 0, 3'd0, 0, 0);
        e0     = pk(1, 8'h06, 8'h30, 0, 3'd0, 1, 0);
        e1     = pk(1, 8'h22, 8'h30, 0, 3'd1, 1, 0);
        ehome1 = pk(1, 8'h00, 8'h00, 1, 3'd1, 1, 0);
        edone  = pk(0, 8'h00, 8'h00, 0, 3'd0, 0, 1);

        // two destinations: load at t, acks at t+3, t+5, t+8
        add(l2, 1, 0, 0, e0);
        add(l2, 0, 0, 0, e0);
        add(l2, 0, 0, 0, e0);
        add(l2, 0, 0, 1, e1);
        add(l2, 0, 0, 0, e1);
        add(l2, 0, 0, 1, ehome1);
        add(l2, 0, 0, 0, ehome1);
        add(l2, 0, 0, 0, ehome1);
        add(l2, 0, 0, 1, edone);
        add(l2, 0, 0, 1, zero);   // ack with nothing presented
        // gap after slot 0
        add(lgap, 1, 0, 0, pk(1, 8'h52, 8'h30, 0, 3'd0, 1, 0));
        add(lgap, 0, 0, 1, pk(1, 8'h00, 8'h00, 1, 3'd0, 1, 0));
        add(lgap, 0, 0, 1, edone);
        add(lgap, 0, 0, 0, zero);
        // empty list
        add('0, 1, 0, 0, edone);
        add('0, 0, 0, 0, zero);
        // abort with ack at idx 1, then abort in HOME
        add(l3, 1, 0, 0, e0);
        add(l3, 0, 0, 1, e1);
        add(l3, 0, 1, 1, ehome1);
        add(l3, 0, 1, 0, ehome1);
        add(l3, 0, 0, 1, edone);
        add(l3, 0, 0, 0, zero);
        // load while busy with a different list
        add(l2, 1, 0, 0, e0);
        add(lalt, 1, 0, 0, e0);
        add(lalt, 0, 0, 1, e1);
        add(lalt, 1, 0, 1, ehome1);
        add(lalt, 0, 0, 1, edone);
        add('0, 0, 0, 0, zero);

        rst_n = 1'b0; destn_in = '0; load = 0; abort = 0; wp_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_h", got_h(), zero);
        check("reset_n", got_n(), zero);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].destn, vecs[i].load, vecs[i].abort, vecs[i].ack);
            check($sformatf("vec%0d", i), got_h(), vecs[i].exp);
        end

        // full list on the no-home build, ack every cycle
        drive(lfull, 1, 0, 0);
        check("full_s0", got_n(), pk(1, fx[0], fy[0], 0, 3'd0, 1, 0));
        for (int k = 0; k < 6; k++) begin
            drive(lfull, 0, 0, 1);
            if (k < 5)
                check($sformatf("full_s%0d", k + 1), got_n(),
                      pk(1, fx[k+1], fy[k+1], 0, 3'(k + 1), 1, 0));
            else
                check("full_done", got_n(), edone);
        end
        check("full_home_h", got_h(), pk(1, 8'h00, 8'h00, 1, 3'd5, 1, 0));
        drive('0, 0, 0, 1);
        check("full_idle_n", got_n(), zero);
        check("full_done_h", got_h(), edone);
        drive('0, 0, 0, 0);

        // asynchronous reset mid-run
        drive(l2, 1, 0, 0);
        drive(l2, 0, 0, 1);
        check("pre_rst", got_h(), e1);
        @(negedge clk);
        wp_ack = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_h", got_h(), zero);
        check("async_rst_n", got_n(), zero);
        for (int k = 0; k < 3; k++) begin
            drive(l2, 0, 0, 0);
            check($sformatf("rst_hold%0d", k), got_h(), zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive('0, 0, 0, 0);
            check($sformatf("post_rst%0d", k), got_h(), zero);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dest_dispatch.md
# dest_dispatch

Consumer side of the destination list built by the order-mapping stage. On a `load` pulse it snapshots the packed 96-bit list of up to six (x, y) destinations. It then hands the destinations to the AGV navigation controller one at a time over a valid/ack handshake. It stops at the first empty slot, optionally issues a final return-to-home waypoint, and pulses `done`.

## Interface
- `N_SLOTS`, 6: number of 16-bit destination slots in `destn_in`.
- `RETURN_HOME`, 1: when 1, a home waypoint follows the last destination.
- `HOME_X`, 8'h00: home x coordinate.
- `HOME_Y`, 8'h00: home y coordinate.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `destn_in` input 16*N_SLOTS: packed list. Slot k has x = bits [16k+7:16k] and y = bits [16k+15:16k+8].
- `load` input 1: single-cycle request to capture `destn_in` and start a run.
- `abort` input 1: single-cycle request to cancel the run.
- `wp_valid` output 1: waypoint is presented.
- `wp_x` output 8: waypoint x.
- `wp_y` output 8: waypoint y.
- `wp_home` output 1: the presented waypoint is the home waypoint.
- `wp_ack` input 1: navigation has reached the presented waypoint.
- `wp_index` output 3: slot number of the presented destination.
- `busy` output 1: high from `load` acceptance until `done`.
- `done` output 1: one-cycle pulse at the end of a run.

## Operation
- **Empty slot rule:** a slot is empty when both its x byte and its y byte are 0.
- **Count:** `count` = number of consecutive non-empty slots starting at slot 0. Slots after the first empty slot are never issued.
- **States:** IDLE, ISSUE, HOME, FIN.
- **IDLE:**
  - `load` captures `destn_in` into an internal snapshot and computes `count`.
  - count > 0: go to ISSUE with idx = 0.
  - count = 0: go to FIN. No home waypoint is issued.
- **ISSUE:**
  - Outputs: `wp_valid`=1, `wp_x`/`wp_y` = slot idx, `wp_index`=idx, `wp_home`=0.
  - On `wp_ack`, if idx+1 < count: idx increments and the state stays in ISSUE.
  - On `wp_ack` otherwise: go to HOME if RETURN_HOME, else FIN.
- **HOME:**
  - Outputs: `wp_valid`=1, `wp_x`=HOME_X, `wp_y`=HOME_Y, `wp_home`=1, `wp_index` holds the last slot number.
  - On `wp_ack`: go to FIN.
- **FIN:** `done`=1 for exactly one cycle, then IDLE.
- **abort** (ISSUE only):
  - RETURN_HOME=1: go to HOME.
  - RETURN_HOME=0: go to FIN.
  - Ignored in IDLE, HOME and FIN.
- **Simultaneous `abort` and `wp_ack` in ISSUE:** abort wins and the ack is consumed.
- **`load` while busy:** ignored. The snapshot is not modified mid-run, even if `destn_in` changes.
- **`wp_ack` while `wp_valid`=0:** ignored.

## Timing
- **Reset values:** state IDLE; `wp_valid`, `wp_home`, `busy`, `done` = 0; `wp_x`, `wp_y`, `wp_index` = 0; snapshot cleared.
- **Reset mid-run:** everything returns immediately to the reset values. No `done` pulse is generated.
- All outputs are registered.
- **Start latency:** with `load` at cycle t, `busy` and `wp_valid` are high at t+1 presenting slot 0.
- **Empty-list latency:** with count = 0, `done` pulses at t+1 and `busy` stays low throughout.
- **Back-to-back waypoints:** `wp_ack` at cycle t updates the waypoint at t+1 with `wp_valid` still high. Zero bubble cycles between waypoints.
- **Final ack:** after the final `wp_ack` at cycle t, `wp_valid`=0 and `done`=1 at t+1, and `busy` falls at t+1.
- **Waypoint stability:** while `wp_valid`=1 and no ack has occurred, `wp_x`/`wp_y`/`wp_home` are stable.
- **Index arithmetic:**
  - idx is 3 bits and never exceeds N_SLOTS-1.
  - `count` ranges 0..N_SLOTS, 3 bits for N_SLOTS ≤ 7.

## Structure
- **Shared package:**
  - Slot width (16) and byte offsets.
  - State encoding.
  - Warehouse coordinate constants (06/30, 22/30, 52/30, 56/90, 82/90, a6/90, home), shared with the order-mapping stage.
- **Sub-module `slot_counter`:** combinational leading-non-empty counter over the packed list.
- Everything else stays in `dest_dispatch`.

## Test plan
- **Two destinations.** Stimulus: slot0=(06,30), slot1=(22,30), rest 0; `load` at t; `wp_ack` at t+3 and t+5.
  - Response: (06,30,idx0) at t+1..t+3, then (22,30,idx1) at t+4..t+5, then home (00,00,wp_home=1) from t+6.
  - After `wp_ack` at t+8: `done` pulses at t+9.
- **Full list, RETURN_HOME=0.** Stimulus: all six standard coordinates; ack every cycle.
  - Response: six waypoints on consecutive cycles, `done` the cycle after the sixth ack, `wp_home` never asserted.
- **Gap in the list.** Stimulus: slot0=(52,30), slot1=0, slot2=(56,90).
  - Response: only (52,30) is issued, then home.
- **Empty list.** Stimulus: `destn_in`=0 with `load` at t.
  - Response: `done` at t+1, `wp_valid` never high.
- **Abort precedence.** Stimulus: `abort` and `wp_ack` together while idx=1.
  - Response: home waypoint next cycle. Slot 2 is never presented.
- **Load while busy and reset.** Stimulus: new `load` with a different `destn_in` mid-run.
  - Response: ignored, the original snapshot is issued unchanged.
  - Stimulus: `rst_n` low mid-run.
  - Response: all outputs 0 immediately and no `done` pulse.
